// File: rtl/dumbrv_pkg.sv
// Shared dumbrv constants: instruction length marker and halfword size.
package dumbrv_pkg;

  // Low two bits of a 32-bit instruction; anything else is compressed
  localparam logic [1:0] INST_LEN_32 = 2'b11;

  // Bytes per halfword fetched from the instruction port
  localparam int HW_BYTES = 2;

  // True when a halfword starts a compressed (16-bit) instruction
  function automatic logic is_short(input logic [15:0] hw);
    return hw[1:0] != INST_LEN_32;
  endfunction

endpackage

// File: rtl/dumbrv_fetch_align.sv
// dumbrv fetch/align: halfword fetch into a small queue, instruction assembly
// (16- or 32-bit, possibly straddling a word), PC tracking and redirect flush.
module dumbrv_fetch_align
  import dumbrv_pkg::*;
#(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4     // halfword queue depth, 2..8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              short_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int                CW    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC0   = RESET_PC & ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(HW_BYTES);
  localparam logic [ADDR_W-1:0] STEP4 = ADDR_W'(2 * HW_BYTES);

  logic [15:0]       r_q [DEPTH];
  logic [CW-1:0]     r_cnt;
  logic              r_drop;      // outstanding request belongs to a flushed stream
  logic [ADDR_W-1:0] r_head_pc;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;

  logic [15:0]       w_hw0, w_hw1;
  logic              w_short, w_valid, w_fire, w_ack, w_push;
  logic [1:0]        w_pop;
  logic [CW-1:0]     w_cnt_next, w_wpos;
  logic [ADDR_W-1:0] w_tgt, w_fetch_next;
  logic [15:0]       w_ext    [DEPTH+2];
  logic [15:0]       w_q_next [DEPTH];

  assign w_hw0   = r_q[0];
  assign w_hw1   = r_q[1];
  assign w_short = is_short(w_hw0);

  // A redirect cycle never hands out an instruction, so the flush is clean
  assign w_valid = !redirect_i &&
                   ((r_cnt >= CW'(1) && w_short) || r_cnt >= CW'(2));
  assign w_fire  = w_valid && inst_ready_i;
  assign w_pop   = !w_fire ? 2'd0 : (w_short ? 2'd1 : 2'd2);

  // Acks only count while a request is actually open; stale data never lands
  assign w_ack   = r_req && mem_ack_i;
  assign w_push  = w_ack && !r_drop && !redirect_i;

  assign w_tgt        = redirect_pc_i & ~ADDR_W'(1);
  assign w_cnt_next   = redirect_i ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_fetch_next = redirect_i ? w_tgt :
                        w_push     ? r_fetch_pc + STEP2 : r_fetch_pc;
  // Slot for the incoming halfword after this cycle's pop has shifted the queue
  assign w_wpos       = r_cnt - CW'(w_pop);

  assign inst_valid_o = w_valid;
  assign short_o      = w_short;
  assign inst_o       = w_short ? {16'h0, w_hw0} : {w_hw1, w_hw0};
  assign inst_pc_o    = r_head_pc;
  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_addr;

  // Next queue contents: shift out popped halfwords, then append the push
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_ext[i] = r_q[i];
    w_ext[DEPTH]   = '0;
    w_ext[DEPTH+1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      case (w_pop)
        2'd1:    w_q_next[i] = w_ext[i+1];
        2'd2:    w_q_next[i] = w_ext[i+2];
        default: w_q_next[i] = w_ext[i];
      endcase
      if (w_push && w_wpos == CW'(i)) w_q_next[i] = mem_rdata_i;
    end
  end

  // Queue, PCs, drop flag and the single-outstanding memory request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q        <= '{default: '0};
      r_cnt      <= '0;
      r_drop     <= 1'b0;
      r_head_pc  <= PC0;
      r_fetch_pc <= PC0;
      r_req      <= 1'b0;
      r_addr     <= PC0;
    end else begin
      r_q        <= w_q_next;
      r_cnt      <= w_cnt_next;
      r_fetch_pc <= w_fetch_next;

      if (redirect_i)  r_head_pc <= w_tgt;
      else if (w_fire) r_head_pc <= r_head_pc + (w_short ? STEP2 : STEP4);

      // An open request that survives the redirect must have its data discarded
      if (redirect_i)  r_drop <= r_req && !mem_ack_i;
      else if (w_ack)  r_drop <= 1'b0;

      // Request and address are frozen until acked; otherwise re-evaluate space
      if (!r_req || mem_ack_i) begin
        r_req  <= w_cnt_next < CW'(DEPTH);
        r_addr <= w_fetch_next;
      end
    end
  end

endmodule

// File: tb/tb_dumbrv_fetch_align.sv
// Bench for dumbrv_fetch_align: directed scenarios plus a randomized run,
// checked against an instruction-stream model that walks memory by PC.
module tb_dumbrv_fetch_align;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_o, mem_ack_i;
  logic [23:0] mem_addr_o, inst_pc_o, redirect_pc_i;
  logic [15:0] mem_rdata_i;
  logic        inst_valid_o, inst_ready_i, short_o, redirect_i;
  logic [31:0] inst_o;

  int total = 0, bad = 0;
  logic [15:0] mem [256];
  int ack_budget = 0;     // -1 unlimited, else number of acks still allowed
  int ack_pct    = 100;
  int hs_cnt     = 0;
  int ack_seen   = 0;
  logic [23:0] last_ack_addr;

  logic [23:0] exp_pc;
  logic [15:0] m_h0, m_h1;
  logic [23:0] m_p2;
  logic [31:0] m_inst;
  logic        pv_req = 1'b0, pv_ack = 1'b0;
  logic [23:0] pv_addr;

  dumbrv_fetch_align #(.ADDR_W(24), .RESET_PC(24'h0), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .short_o(short_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  // Memory responder: decides the ack for the current cycle after inputs settle
  initial begin
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_req_o && ack_budget != 0 && int'($urandom_range(0, 99)) < ack_pct) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem[mem_addr_o[8:1]];
        if (ack_budget > 0) ack_budget--;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'($urandom);
      end
    end
  end

  // Reference: instruction stream derived from memory contents and the PC walk
  always @(negedge clk) begin
    if (rst_i) begin
      exp_pc = 24'h0;
      pv_req = 1'b0;
    end else begin
      if (pv_req && !pv_ack) begin
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== pv_addr) begin
          bad++;
          $display("FAIL req_stable: req=%0b addr=%h, want req=1 addr=%h", mem_req_o, mem_addr_o, pv_addr);
        end
      end
      total++;
      if (mem_addr_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL addr_bit0: addr=%h", mem_addr_o);
      end
      if (mem_req_o && mem_ack_i) begin
        ack_seen++;
        last_ack_addr = mem_addr_o;
      end
      if (redirect_i) begin
        total++;
        if (inst_valid_o !== 1'b0) begin
          bad++;
          $display("FAIL valid_on_redirect: valid=%0b want 0", inst_valid_o);
        end
        exp_pc = redirect_pc_i & ~24'h1;
      end else if (inst_valid_o && inst_ready_i) begin
        m_h0 = mem[exp_pc[8:1]];
        m_p2 = exp_pc + 24'd2;
        m_h1 = mem[m_p2[8:1]];
        m_inst = (m_h0[1:0] == 2'b11) ? {m_h1, m_h0} : {16'h0, m_h0};
        total++;
        if (inst_o !== m_inst || inst_pc_o !== exp_pc || short_o !== (m_h0[1:0] != 2'b11)) begin
          bad++;
          $display("FAIL stream: inst=%h pc=%h short=%0b, want inst=%h pc=%h", inst_o, inst_pc_o, short_o, m_inst, exp_pc);
        end
        exp_pc = exp_pc + ((m_h0[1:0] == 2'b11) ? 24'd4 : 24'd2);
        hs_cnt++;
      end
      pv_req  = mem_req_o;
      pv_ack  = mem_ack_i;
      pv_addr = mem_addr_o;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1; inst_ready_i = 1'b0; redirect_i = 1'b0; ack_budget = 0; ack_pct = 100;
    step; step;
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic wait_hs(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (inst_valid_o && inst_ready_i) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    do_reset;
    fill_mem(16'h0001); mem[0] = 16'h4501;
    @(negedge clk);
    total++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 24'h0 || inst_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_vals: req=%0b addr=%h valid=%0b want 0/0/0", mem_req_o, mem_addr_o, inst_valid_o);
    end
    rst_i = 1'b0;
    step;
    @(negedge clk);
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 24'h0) begin
      bad++; $display("FAIL first_req: req=%0b addr=%h want 1/000000", mem_req_o, mem_addr_o);
    end
    // reset while the request is open, with an ack landing in the reset cycle
    step; rst_i = 1'b1; ack_budget = -1;
    step; rst_i = 1'b0; ack_budget = 0;
    @(negedge clk);
    total++;
    if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid: req=%0b valid=%0b want 0/0", mem_req_o, inst_valid_o);
    end
    step;
    @(negedge clk);
    total++;
    if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 24'h0) begin
      bad++; $display("FAIL reset_ack_ignored: valid=%0b req=%0b addr=%h want 0/1/0", inst_valid_o, mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_compressed;
    logic ok;
    do_reset;
    fill_mem(16'h0001); mem[0] = 16'h4501; mem[1] = 16'h0001;
    inst_ready_i = 1'b1; ack_budget = -1; rst_i = 1'b0;
    wait_hs(20, ok);
    total++;
    if (!ok || inst_o !== 32'h00004501 || short_o !== 1'b1 || inst_pc_o !== 24'h0) begin
      bad++; $display("FAIL comp_first: ok=%0b inst=%h short=%0b pc=%h want 00004501/1/0", ok, inst_o, short_o, inst_pc_o);
    end
    wait_hs(20, ok);
    total++;
    if (!ok || inst_o !== 32'h00000001 || inst_pc_o !== 24'h2) begin
      bad++; $display("FAIL comp_second: ok=%0b inst=%h pc=%h want 00000001/2", ok, inst_o, inst_pc_o);
    end
  endtask

  task automatic test_32bit;
    logic ok;
    do_reset;
    fill_mem(16'h0001); mem[0] = 16'h0513; mem[1] = 16'h00A0;
    inst_ready_i = 1'b1; ack_budget = 1; rst_i = 1'b0;
    step; step; step;
    @(negedge clk);
    total++;
    if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 24'h2) begin
      bad++; $display("FAIL half_only: valid=%0b req=%0b addr=%h want 0/1/2", inst_valid_o, mem_req_o, mem_addr_o);
    end
    step; ack_budget = -1;
    wait_hs(20, ok);
    total++;
    if (!ok || inst_o !== 32'h00A00513 || short_o !== 1'b0 || inst_pc_o !== 24'h0) begin
      bad++; $display("FAIL full32: ok=%0b inst=%h short=%0b pc=%h want 00A00513/0/0", ok, inst_o, short_o, inst_pc_o);
    end
    wait_hs(20, ok);
    total++;
    if (!ok || inst_pc_o !== 24'h4 || inst_o !== 32'h00000001) begin
      bad++; $display("FAIL after32: ok=%0b inst=%h pc=%h want 00000001/4", ok, inst_o, inst_pc_o);
    end
  endtask

  task automatic test_straddle;
    logic ok;
    do_reset;
    fill_mem(16'h0001); mem[0] = 16'h4501; mem[1] = 16'h0513; mem[2] = 16'h00A0;
    inst_ready_i = 1'b1; ack_budget = -1; rst_i = 1'b0;
    wait_hs(20, ok);
    total++;
    if (!ok || inst_o !== 32'h00004501 || inst_pc_o !== 24'h0) begin
      bad++; $display("FAIL strad_first: ok=%0b inst=%h pc=%h want 00004501/0", ok, inst_o, inst_pc_o);
    end
    wait_hs(20, ok);
    total++;
    if (!ok || inst_o !== 32'h00A00513 || short_o !== 1'b0 || inst_pc_o !== 24'h2) begin
      bad++; $display("FAIL strad_32: ok=%0b inst=%h short=%0b pc=%h want 00A00513/0/2", ok, inst_o, short_o, inst_pc_o);
    end
  endtask

  task automatic test_redirect_drop;
    logic ok, found;
    do_reset;
    fill_mem(16'h0001); mem[3] = 16'hFFFF; mem[8'h80] = 16'h4501;
    ack_budget = 3; rst_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step;
      if (mem_req_o && mem_addr_o == 24'h6) found = 1'b1;
    end
    redirect_i = 1'b1; redirect_pc_i = 24'h000101;
    @(negedge clk);
    total++;
    if (!found || inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 24'h6) begin
      bad++; $display("FAIL redir_hold: found=%0b valid=%0b req=%0b addr=%h want 1/0/1/6", found, inst_valid_o, mem_req_o, mem_addr_o);
    end
    step; redirect_i = 1'b0;
    step; step; ack_budget = 1;
    step;
    @(negedge clk);
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 24'h100 || inst_valid_o !== 1'b0) begin
      bad++; $display("FAIL redir_newreq: req=%0b addr=%h valid=%0b want 1/100/0", mem_req_o, mem_addr_o, inst_valid_o);
    end
    step; ack_budget = -1; inst_ready_i = 1'b1;
    wait_hs(20, ok);
    total++;
    if (!ok || inst_pc_o !== 24'h100 || inst_o !== 32'h00004501) begin
      bad++; $display("FAIL redir_first: ok=%0b inst=%h pc=%h want 00004501/100", ok, inst_o, inst_pc_o);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    fill_mem(16'h0001);
    ack_budget = -1; ack_seen = 0; rst_i = 1'b0;
    repeat (12) step;
    @(negedge clk);
    total++;
    if (ack_seen != 4 || last_ack_addr !== 24'h6 || mem_req_o !== 1'b0 || inst_valid_o !== 1'b1) begin
      bad++; $display("FAIL full_stop: acks=%0d last=%h req=%0b valid=%0b want 4/6/0/1", ack_seen, last_ack_addr, mem_req_o, inst_valid_o);
    end
    step; inst_ready_i = 1'b1;
    step; inst_ready_i = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 24'h8) begin
      bad++; $display("FAIL resume: req=%0b addr=%h want 1/8", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_redirect_ack;
    logic ok, found;
    do_reset;
    fill_mem(16'h0001); mem[8'h20] = 16'h4501;
    ack_budget = -1; rst_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step;
      if (mem_req_o && mem_addr_o == 24'h4) found = 1'b1;
    end
    redirect_i = 1'b1; redirect_pc_i = 24'h000040; inst_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (!found || inst_valid_o !== 1'b0 || mem_ack_i !== 1'b1) begin
      bad++; $display("FAIL rack_cycle: found=%0b valid=%0b ack=%0b want 1/0/1", found, inst_valid_o, mem_ack_i);
    end
    step; redirect_i = 1'b0; inst_ready_i = 1'b0; ack_budget = 0;
    @(negedge clk);
    total++;
    if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 24'h40) begin
      bad++; $display("FAIL rack_after: valid=%0b req=%0b addr=%h want 0/1/40", inst_valid_o, mem_req_o, mem_addr_o);
    end
    step; ack_budget = -1; inst_ready_i = 1'b1;
    wait_hs(20, ok);
    total++;
    if (!ok || inst_pc_o !== 24'h40 || inst_o !== 32'h00004501) begin
      bad++; $display("FAIL rack_first: ok=%0b inst=%h pc=%h want 00004501/40", ok, inst_o, inst_pc_o);
    end
  endtask

  task automatic test_random;
    logic [15:0] r;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) r[1:0] = 2'b11;
      mem[i] = r;
    end
    ack_budget = -1; hs_cnt = 0; rst_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step;
      if (c % 100 == 0) ack_pct = int'($urandom_range(30, 100));
      inst_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) begin
        redirect_i = 1'b1;
        redirect_pc_i = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 | 24'($urandom_range(0, 15)))
                                                   : 24'($urandom_range(0, 511));
      end else begin
        redirect_i = 1'b0;
      end
    end
    step; redirect_i = 1'b0; inst_ready_i = 1'b0;
    @(negedge clk);
    total++;
    if (hs_cnt < 300) begin
      bad++; $display("FAIL rand_progress: handshakes=%0d want >=300", hs_cnt);
    end
  endtask

  initial begin
    rst_i = 1'b1; inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    test_reset;
    test_compressed;
    test_32bit;
    test_straddle;
    test_redirect_drop;
    test_back_to_back;
    test_redirect_ack;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
